// File: rtl/echo_filter_pkg.sv
// Shared constants and types for the echo range filter.
// Width defaults, derived accumulator width and the alarm FSM state type.
package echo_filter_pkg;

    localparam int unsigned WIDTH_DEF      = 24;
    localparam int unsigned LOG2_DEPTH_DEF = 3;
    localparam int unsigned SUM_W          = WIDTH_DEF + LOG2_DEPTH_DEF;
    localparam int unsigned DEPTH          = 1 << LOG2_DEPTH_DEF;

    localparam logic [WIDTH_DEF-1:0] MIN_WIDTH_RST = '1;

    typedef enum logic [0:0] {
        StClear,
        StNear
    } alarm_state_e;

endpackage

// File: rtl/echo_sample_ring.sv
// Ring buffer of accepted echo widths with write pointer, fill level and
// a read port exposing the entry about to be overwritten.
module echo_sample_ring
    import echo_filter_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned LOG2_DEPTH = LOG2_DEPTH_DEF
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      oldest,
    output logic [LOG2_DEPTH:0]   fill
);

    localparam int unsigned Depth = 1 << LOG2_DEPTH;

    logic [WIDTH-1:0]      mem_q [Depth];
    logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2_DEPTH:0]   fill_q, fill_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        if (flush) begin
            wr_ptr_d = '0;
            fill_d   = '0;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (fill_q != (LOG2_DEPTH+1)'(Depth)) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Contents need no reset: fill decides which entries are meaningful.
    always_ff @(posedge PCLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign oldest = mem_q[wr_ptr_q];
    assign fill   = fill_q;

endmodule

// File: rtl/echo_range_filter.sv
// Echo-width smoothing stage: 8-sample moving average, running min/max,
// saturating timeout counter and a hysteretic near-object alarm.
module echo_range_filter
    import echo_filter_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned LOG2_DEPTH = LOG2_DEPTH_DEF
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             flush,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_width,
    input  logic             s_timeout,
    input  logic [WIDTH-1:0] thr_near,
    input  logic [WIDTH-1:0] thr_far,
    output logic [WIDTH-1:0] avg_width,
    output logic             avg_valid,
    output logic             avg_strobe,
    output logic [WIDTH-1:0] min_width,
    output logic [WIDTH-1:0] max_width,
    output logic             alarm,
    output logic [7:0]       drop_count
);

    localparam int unsigned Depth = 1 << LOG2_DEPTH;
    localparam int unsigned SumW  = WIDTH + LOG2_DEPTH;
    localparam int unsigned FillW = LOG2_DEPTH + 1;

    logic             accept, drop;
    logic [WIDTH-1:0] oldest;
    logic [FillW-1:0] fill;
    logic             full;

    logic [SumW-1:0]  sum_q, sum_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] min_q, min_d, max_q, max_d;
    logic [7:0]       drop_q, drop_d;
    logic [WIDTH-1:0] avg_q, avg_d;
    logic             avg_valid_q, avg_valid_d;
    logic             avg_strobe_q, avg_strobe_d;
    logic [WIDTH-1:0] avg_new;

    alarm_state_e state_q, state_d;

    assign accept = s_valid & ~s_timeout & ~flush;
    assign drop   = s_valid & s_timeout & ~flush;
    assign full   = (fill == FillW'(Depth));

    echo_sample_ring #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .flush   (flush),
        .wr_en   (accept),
        .wr_data (s_width),
        .oldest  (oldest),
        .fill    (fill)
    );

    // Sample stage: sum, min/max, drops; pend_q marks a full-window update.
    always_comb begin
        sum_d  = sum_q;
        min_d  = min_q;
        max_d  = max_q;
        drop_d = drop_q;
        pend_d = 1'b0;
        if (flush) begin
            sum_d  = '0;
            min_d  = '1;
            max_d  = '0;
            drop_d = '0;
        end else if (accept) begin
            if (full) begin
                sum_d = sum_q + SumW'(s_width) - SumW'(oldest);
            end else begin
                sum_d = sum_q + SumW'(s_width);
            end
            if (s_width < min_q) min_d = s_width;
            if (s_width > max_q) max_d = s_width;
            pend_d = full || (fill == FillW'(Depth - 1));
        end else if (drop && drop_q != 8'hff) begin
            drop_d = drop_q + 8'd1;
        end
    end

    assign avg_new = WIDTH'(sum_q >> LOG2_DEPTH);

    // Output stage: registers the average one cycle after the sample stage.
    always_comb begin
        avg_d        = avg_q;
        avg_valid_d  = avg_valid_q;
        avg_strobe_d = 1'b0;
        if (flush) begin
            avg_d       = '0;
            avg_valid_d = 1'b0;
        end else if (pend_q) begin
            avg_d        = avg_new;
            avg_valid_d  = 1'b1;
            avg_strobe_d = 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sum_q        <= '0;
            pend_q       <= 1'b0;
            min_q        <= '1;
            max_q        <= '0;
            drop_q       <= '0;
            avg_q        <= '0;
            avg_valid_q  <= 1'b0;
            avg_strobe_q <= 1'b0;
        end else begin
            sum_q        <= sum_d;
            pend_q       <= pend_d;
            min_q        <= min_d;
            max_q        <= max_d;
            drop_q       <= drop_d;
            avg_q        <= avg_d;
            avg_valid_q  <= avg_valid_d;
            avg_strobe_q <= avg_strobe_d;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= StClear;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StClear;
        end else if (pend_q) begin
            unique case (state_q)
                StClear: if (avg_new < thr_near) state_d = StNear;
                StNear:  if (avg_new > thr_far)  state_d = StClear;
                default: state_d = StClear;
            endcase
        end
    end

    always_comb begin
        alarm = (state_q == StNear);
    end

    assign avg_width  = avg_q;
    assign avg_valid  = avg_valid_q;
    assign avg_strobe = avg_strobe_q;
    assign min_width  = min_q;
    assign max_width  = max_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_echo_range_filter.sv
// Self-checking bench for echo_range_filter: directed scenarios plus a
// randomized run against a queue-based window model.
module tb_echo_range_filter;

    localparam int W = 24;

    logic         PCLK = 1'b0;
    logic         PRESET = 1'b1;
    logic         flush = 1'b0;
    logic         s_valid = 1'b0;
    logic [W-1:0] s_width = '0;
    logic         s_timeout = 1'b0;
    logic [W-1:0] thr_near = '0;
    logic [W-1:0] thr_far = '1;
    logic [W-1:0] avg_width;
    logic         avg_valid;
    logic         avg_strobe;
    logic [W-1:0] min_width;
    logic [W-1:0] max_width;
    logic         alarm;
    logic [7:0]   drop_count;

    echo_range_filter dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .flush      (flush),
        .s_valid    (s_valid),
        .s_width    (s_width),
        .s_timeout  (s_timeout),
        .thr_near   (thr_near),
        .thr_far    (thr_far),
        .avg_width  (avg_width),
        .avg_valid  (avg_valid),
        .avg_strobe (avg_strobe),
        .min_width  (min_width),
        .max_width  (max_width),
        .alarm      (alarm),
        .drop_count (drop_count)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] all_ones = '1;

    // Reference model: the window is the last eight accepted samples.
    longint unsigned win[$];
    longint unsigned m_min, m_max, m_avg, m_pend_avg;
    int              m_drop;
    bit              m_valid, m_strobe, m_alarm, m_pend;

    task automatic model_clear();
        win.delete();
        m_min = 64'hff_ffff; m_max = 0; m_drop = 0;
        m_avg = 0; m_valid = 0; m_strobe = 0; m_alarm = 0; m_pend = 0;
    endtask

    task automatic model_edge(input bit v, input longint unsigned w, input bit to,
                              input bit fl, input bit rst);
        longint unsigned s;
        bit              new_pend;
        if (rst) begin
            model_clear();
            return;
        end
        if (fl) begin
            m_avg = 0; m_valid = 0; m_strobe = 0; m_alarm = 0;
        end else if (m_pend) begin
            m_avg = m_pend_avg; m_valid = 1; m_strobe = 1;
            if (m_avg < thr_near) m_alarm = 1;
            else if (m_avg > thr_far) m_alarm = 0;
        end else begin
            m_strobe = 0;
        end
        new_pend = 0;
        if (fl) begin
            win.delete(); m_min = 64'hff_ffff; m_max = 0; m_drop = 0;
        end else if (v && to) begin
            if (m_drop < 255) m_drop++;
        end else if (v) begin
            win.push_back(w);
            if (win.size() > 8) void'(win.pop_front());
            if (w < m_min) m_min = w;
            if (w > m_max) m_max = w;
            if (win.size() == 8) begin
                s = 0;
                foreach (win[i]) s += win[i];
                m_pend_avg = s / 8;
                new_pend = 1;
            end
        end
        m_pend = new_pend;
    endtask

    // One clock: drive at negedge, update model at posedge, leave #1 for sampling.
    task automatic step(input bit v, input longint unsigned w, input bit to,
                        input bit fl, input bit rst);
        @(negedge PCLK);
        s_valid = v; s_width = W'(w); s_timeout = to; flush = fl; PRESET = rst;
        @(posedge PCLK);
        model_edge(v, w, to, fl, rst);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        idle();
        checks++;
        if (avg_width !== '0 || avg_valid !== 1'b0 || avg_strobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_avg: got avg=%0d valid=%0b strobe=%0b, expected 0/0/0",
                     avg_width, avg_valid, avg_strobe);
        end
        checks++;
        if (min_width !== all_ones || max_width !== '0) begin
            errors++;
            $display("FAIL reset_minmax: got min=%0h max=%0d, expected ffffff/0",
                     min_width, max_width);
        end
        checks++;
        if (alarm !== 1'b0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_alarm_drop: got alarm=%0b drop=%0d, expected 0/0",
                     alarm, drop_count);
        end
    endtask

    task automatic test_fill();
        int early = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1, 100 * i, 0, 0, 0);
            if (avg_strobe !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL fill_no_early_strobe: got %0d strobes, expected 0", early);
        end
        idle();
        checks++;
        if (avg_strobe !== 1'b1 || avg_width !== 24'd450 || avg_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_avg: got strobe=%0b avg=%0d valid=%0b, expected 1/450/1",
                     avg_strobe, avg_width, avg_valid);
        end
        checks++;
        if (min_width !== 24'd100 || max_width !== 24'd800) begin
            errors++;
            $display("FAIL fill_minmax: got min=%0d max=%0d, expected 100/800",
                     min_width, max_width);
        end
        idle();
        checks++;
        if (avg_strobe !== 1'b0) begin
            errors++;
            $display("FAIL fill_strobe_pulse: got strobe=%0b, expected 0", avg_strobe);
        end
    endtask

    task automatic test_wrap();
        step(1, 900, 0, 0, 0);
        idle();
        checks++;
        if (avg_strobe !== 1'b1 || avg_width !== 24'd550 || max_width !== 24'd900) begin
            errors++;
            $display("FAIL wrap_avg: got strobe=%0b avg=%0d max=%0d, expected 1/550/900",
                     avg_strobe, avg_width, max_width);
        end
    endtask

    task automatic test_drop();
        int strobes = 0;
        for (int i = 0; i < 300; i++) begin
            step(1, $urandom_range(0, 5000), 1, 0, 0);
            if (avg_strobe) strobes++;
        end
        checks++;
        if (drop_count !== 8'd255) begin
            errors++;
            $display("FAIL drop_saturate: got %0d, expected 255", drop_count);
        end
        checks++;
        if (avg_width !== 24'd550 || min_width !== 24'd100 || max_width !== 24'd900
            || strobes != 0) begin
            errors++;
            $display("FAIL drop_unchanged: got avg=%0d min=%0d max=%0d strobes=%0d, expected 550/100/900/0",
                     avg_width, min_width, max_width, strobes);
        end
    endtask

    task automatic test_alarm();
        int bad = 0;
        thr_near = 24'd1000;
        thr_far  = 24'd1500;
        for (int phase = 0; phase < 3; phase++) begin
            int w = (phase == 0) ? 900 : (phase == 1) ? 1200 : 1600;
            bit want = (phase == 2) ? 1'b0 : 1'b1;
            for (int i = 0; i < 8; i++) begin
                step(1, w, 0, 0, 0);
                if (alarm !== m_alarm) bad++;
            end
            idle();
            idle();
            checks++;
            if (alarm !== want || avg_width !== W'(w)) begin
                errors++;
                $display("FAIL alarm_steady_%0d: got alarm=%0b avg=%0d, expected %0b/%0d",
                         w, alarm, avg_width, want, w);
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL alarm_track: got %0d cycle mismatches, expected 0", bad);
        end
    endtask

    task automatic test_flush_collision();
        step(1, 50, 1, 0, 0);
        step(1, 50, 0, 1, 0);
        checks++;
        if (avg_width !== '0 || avg_valid !== 1'b0 || alarm !== 1'b0 || drop_count !== 8'd0
            || min_width !== all_ones || max_width !== '0) begin
            errors++;
            $display("FAIL flush_reset_values: got avg=%0d valid=%0b alarm=%0b drop=%0d min=%0h max=%0d, expected 0/0/0/0/ffffff/0",
                     avg_width, avg_valid, alarm, drop_count, min_width, max_width);
        end
        for (int i = 0; i < 7; i++) step(1, 10, 0, 0, 0);
        idle();
        idle();
        checks++;
        if (avg_valid !== 1'b0 || min_width !== 24'd10 || max_width !== 24'd10) begin
            errors++;
            $display("FAIL flush_sample_ignored: got valid=%0b min=%0d max=%0d, expected 0/10/10",
                     avg_valid, min_width, max_width);
        end
        step(1, 10, 0, 0, 0);
        idle();
        checks++;
        if (avg_strobe !== 1'b1 || avg_width !== 24'd10) begin
            errors++;
            $display("FAIL flush_refill: got strobe=%0b avg=%0d, expected 1/10",
                     avg_strobe, avg_width);
        end
    endtask

    task automatic test_reset_collision();
        int strobes = 0;
        int valids = 0;
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 500, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        if (avg_strobe) strobes++;
        if (avg_valid) valids++;
        for (int i = 0; i < 4; i++) begin
            idle();
            if (avg_strobe) strobes++;
            if (avg_valid) valids++;
        end
        checks++;
        if (strobes != 0 || valids != 0) begin
            errors++;
            $display("FAIL reset_collision: got strobes=%0d valids=%0d, expected 0/0",
                     strobes, valids);
        end
    endtask

    task automatic test_random();
        int bad_avg = 0, bad_ctl = 0, bad_mm = 0, bad_alarm = 0, bad_drop = 0;
        thr_near = W'($urandom_range(200, 600));
        thr_far  = thr_near + W'(200);
        for (int i = 0; i < 600; i++) begin
            bit v = ($urandom_range(0, 9) < 7);
            bit to = ($urandom_range(0, 19) < 3);
            bit fl = ($urandom_range(0, 49) == 0);
            bit rst = ($urandom_range(0, 99) == 0);
            longint unsigned w = ($urandom_range(0, 7) == 0) ? longint'($urandom & 32'hff_ffff)
                                                            : longint'($urandom_range(0, 1000));
            step(v, w, to, fl, rst);
            if (avg_width !== W'(m_avg)) bad_avg++;
            if (avg_valid !== m_valid || avg_strobe !== m_strobe) bad_ctl++;
            if (min_width !== W'(m_min) || max_width !== W'(m_max)) bad_mm++;
            if (alarm !== m_alarm) bad_alarm++;
            if (drop_count !== 8'(m_drop)) bad_drop++;
        end
        checks++;
        if (bad_avg != 0) begin
            errors++;
            $display("FAIL random_avg: got %0d mismatching cycles, expected 0", bad_avg);
        end
        checks++;
        if (bad_ctl != 0) begin
            errors++;
            $display("FAIL random_valid_strobe: got %0d mismatching cycles, expected 0", bad_ctl);
        end
        checks++;
        if (bad_mm != 0) begin
            errors++;
            $display("FAIL random_minmax: got %0d mismatching cycles, expected 0", bad_mm);
        end
        checks++;
        if (bad_alarm != 0) begin
            errors++;
            $display("FAIL random_alarm: got %0d mismatching cycles, expected 0", bad_alarm);
        end
        checks++;
        if (bad_drop != 0) begin
            errors++;
            $display("FAIL random_drop: got %0d mismatching cycles, expected 0", bad_drop);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_fill();
        test_wrap();
        test_drop();
        test_alarm();
        test_flush_collision();
        test_reset_collision();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
